boa_peri_bridge: RTL

BOA_PERI_BRIDGE -- requirements
Module: boa_peri_bridge

---
 rtl/boa_peri_pkg.sv | 15 +
 rtl/boa_mem_bus.sv | 22 ++
 rtl/boa_peri_watchdog.sv | 23 ++
 rtl/boa_peri_bridge.sv | 112 +++++++++++
 4 files changed

// File: rtl/boa_peri_pkg.sv
// Shared types and constants for the CPU-to-peripheral MMIO bridge.
package boa_peri_pkg;

  localparam int ALEN = 32;

  localparam logic [31:0] ERR_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/boa_mem_bus.sv
// Word-addressed memory bus with byte write mask and single-cycle ready.
interface boa_mem_bus;
  import boa_peri_pkg::*;

  logic [ALEN-1:2] addr;
  logic            re;
  logic [3:0]      we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;

  modport MEM (
    input  addr, re, we, wdata,
    output rdata, ready
  );

  modport CPU (
    output addr, re, we, wdata,
    input  rdata, ready
  );

endinterface

// File: rtl/boa_peri_watchdog.sv
// Cycle counter for peripheral waits; used when BOA_PERI_TIMEOUT_EN is set.
module boa_peri_watchdog (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= run ? cnt_q + 16'd1 : '0;
    end
  end

  // Fires on the limit-th consecutive run cycle.
  assign expired = run && (cnt_q == limit - 16'd1);

endmodule

// File: rtl/boa_peri_bridge.sv
// CPU-to-peripheral bridge: latches a request, replays it on the peri bus.
// Optional wait timeout enabled by defining BOA_PERI_TIMEOUT_EN.
module boa_peri_bridge
  import boa_peri_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
  input  logic    clk,
  input  logic    rst,
  boa_mem_bus.MEM cpu,
  boa_mem_bus.CPU peri,
  output logic    timeout_err
);

  if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("boa_peri_bridge: TIMEOUT out of range");
  end

  state_t          state_q;
  state_t          state_d;
  logic [ALEN-1:2] addr_q;
  logic            re_q;
  logic [3:0]      we_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            take;
  logic            abort;
  logic            in_req;
  logic            expired;

  assign in_req = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu.re || |cpu.we) begin
          take    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (peri.ready) begin
          state_d = DATA;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      DATA:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= cpu.addr;
        re_q    <= cpu.re;
        we_q    <= cpu.we;
        wdata_q <= cpu.wdata;
      end
      // Write-only transfers report zero.
      if (state_q == DATA) begin
        rdata_q <= re_q ? peri.rdata : '0;
      end else if (abort) begin
        rdata_q <= re_q ? ERR_WORD : '0;
      end
    end
  end

  assign cpu.ready  = (state_q == RESP);
  assign cpu.rdata  = cpu.ready ? rdata_q : '0;
  assign peri.addr  = addr_q;
  assign peri.wdata = wdata_q;
  assign peri.re    = in_req & re_q;
  assign peri.we    = in_req ? we_q : 4'b0000;

`ifdef BOA_PERI_TIMEOUT_EN
  boa_peri_watchdog u_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (in_req),
    .limit   (16'(TIMEOUT)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
